control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control unit that drives the datapath's register/bus control strobes.
//  Fetches through PC/MAR/MDR/IR, decodes IR, and sequences execute steps T3..T7.
//  Handshakes with memory via mem_ready, counts retired instructions, halts on HALT
//  or memory timeout.
// PARAMETERS
//  WAIT_LIMIT  16  max cycles waiting for mem_ready; 0 = wait forever
//  CNT_W       32  width of instr_count
// PORTS
//  clock        in   1   single clock, all state updates on rising edge
//  clear        in   1   asynchronous, active-low reset
//  ir           in   32  IR contents: op=[31:27] ra=[26:23] rb=[22:19] rc=[18:15]
//  mem_ready    in   1   memory done (read data valid on MDatain / write accepted)
//  stop         in   1   pause request, honoured only at fetch boundary T0
//  reg_in       out  16  one-hot R0in..R15in
//  reg_out      out  16  one-hot R0out..R15out
//  PCout,IncPC,MARin,MDRin,MDRread,MDRout,IRin,Yin,Zin,Zlowout,Zhighout,HIin,HIout,LOin,LOout,Cout  out 1 each
//  ALUselect    out  4   ADD0 SUB1 AND2 OR3 SHR4 SHL5 ROR6 ROL7 MUL8 DIV9 NEG10 NOT11
//  mem_read, mem_write  out 1  memory request, held until mem_ready
//  run          out  1   1 while executing; 0 in pause/HALT
//  illegal_op   out  1   one-cycle pulse in T3 for undefined opcode
//  mem_timeout  out  1   sticky; set on WAIT_LIMIT expiry, cleared only by reset
//  instr_count  out  CNT_W  instructions retired (wraps modulo 2^CNT_W)
// BEHAVIOUR
//  - Reset (clear=0, async): state=T0, all strobes 0, ALUselect=0, run=1, count=0, flags 0.
//  - Moore outputs: decoded from registered state + ir; at most one reg_out/bus driver per cycle.
//  - States: T0 T1 T2 T3 T4 T5 T6 T7 HALT. Unused steps of an opcode jump back to T0.
//  - Fetch: T0 PCout,MARin,IncPC | T1 mem_read,MDRread,MDRin; stay until mem_ready=1 | T2 MDRout,IRin.
//  - T0 with stop=1: no strobes, run=0, stay in T0; resume the cycle after stop=0.
//  - Opcodes: ADD..ROL 0-7 (rc), ADDI 8 ANDI 9 ORI 10, MUL 11 DIV 12, NEG 13 NOT 14,
//    LD 15 ST 16, MFHI 17 MFLO 18, NOP 19, HALT 20; 21-31 illegal.
//  - R-type: T3 rb out,Yin | T4 rc out,ALUselect,Zin | T5 Zlowout,ra in -> T0.
//  - Imm: as R-type but T4 drives Cout instead of rc out; ALUselect ADD/AND/OR.
//  - MUL/DIV: T3 ra out,Yin | T4 rb out,ALU 8/9,Zin | T5 Zlowout,LOin | T6 Zhighout,HIin -> T0.
//  - NEG/NOT: T3 rb out,Yin | T4 rb out,ALU 10/11,Zin | T5 Zlowout,ra in -> T0.
//  - LD: T3 rb out,Yin | T4 Cout,ALU ADD,Zin | T5 Zlowout,MARin | T6 mem_read,MDRread,MDRin
//        until mem_ready | T7 MDRout,ra in -> T0.
//  - ST: T3-T5 as LD | T6 ra out,MDRin (MDRread=0) | T7 mem_write until mem_ready -> T0.
//  - MFHI/MFLO: T3 HIout/LOout, ra in -> T0.  NOP: T3 no strobes -> T0.
//  - Illegal: illegal_op=1 in T3, no strobes, -> T0 (retired like NOP).
//  - HALT: T3 -> HALT; HALT stays (run=0, no strobes) until reset.
//  - instr_count increments on the cycle leaving the final step of each instruction
//    (including NOP/illegal; HALT increments once on entry to HALT).
//  - Wait counter: zeroed on entering a wait state, +1 each cycle mem_ready=0; reaching
//    WAIT_LIMIT-1 with mem_ready still 0 -> mem_timeout=1, go HALT, drop mem_read/mem_write.
//  - mem_ready=1 outside a wait state is ignored. mem_ready in the same cycle as expiry wins.
//  - Reset mid-instruction: async return to T0; a partially done write is not retried.
// TESTING
//  1. Reset, mem_ready=1 always, IR=ADD r3,r1,r2 -> T0..T5 = 6 cycles; T5 reg_in=0x0008, Zlowout=1; count=1.
//  2. LD r4,8(r2), mem_ready delayed 3 cycles in T1 and T6 -> T1/T6 each held 4 cycles, T7 reg_in=0x0010.
//  3. MUL r5,r6 -> T5 LOin=1, T6 HIin=1, ALUselect=8 in T4, no reg_in asserted.
//  4. mem_ready held 0 with WAIT_LIMIT=16 -> mem_timeout=1 after 16 wait cycles, state HALT, run=0.
//  5. stop=1 at T0 for 5 cycles, then opcode 25 -> no strobes while paused; illegal_op pulse in T3; count+1.
//  6. clear=0 asserted during ST T7 -> all outputs 0 at once; after release fetch restarts at T0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the sequencer's instruction/handshake inputs and every control
//   strobe it drives into the datapath and memory.
//   master : the sequencer (drives strobes, status, instr_count)
//   slave  : datapath / memory side (drives ir, mem_ready, stop)
//   Signals:
//     ir[31:0]         instruction register contents
//     mem_ready        memory done (read data valid / write accepted)
//     stop             pause request, honoured at the fetch boundary
//     reg_in/reg_out   one-hot register file load / drive enables
//     PCout..Cout      single-bit bus and register strobes
//     ALUselect[3:0]   ALU operation code
//     mem_read/write   memory request, held until mem_ready
//     run              executing (0 while paused or halted)
//     illegal_op       pulse in T3 for an undefined opcode
//     mem_timeout      sticky memory-timeout flag
//     instr_count      retired instruction counter
interface control_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ir;
    logic             mem_ready;
    logic             stop;
    logic [15:0]      reg_in;
    logic [15:0]      reg_out;
    logic             PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin;
    logic             Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout;
    logic [3:0]       ALUselect;
    logic             mem_read, mem_write;
    logic             run, illegal_op, mem_timeout;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  ir, mem_ready, stop,
        output reg_in, reg_out,
               PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin,
               Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
               ALUselect, mem_read, mem_write,
               run, illegal_op, mem_timeout, instr_count
    );

    modport slave (
        output ir, mem_ready, stop,
        input  reg_in, reg_out,
               PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin,
               Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
               ALUselect, mem_read, mem_write,
               run, illegal_op, mem_timeout, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle control unit. Fetches through PC/MAR/MDR/IR (T0..T2), decodes
//   the IR and sequences execute steps T3..T7, then returns to T0. Memory
//   accesses wait on mem_ready with an optional timeout that halts the core.
//   Ports:
//     clock  rising-edge clock
//     clear  asynchronous active-low reset
//     bus    control_sequencer_if.master (instruction, handshake, strobes,
//            run/illegal_op/mem_timeout status, instr_count)
//   Parameters:
//     WAIT_LIMIT  max cycles waiting for mem_ready (0 = wait forever)
//     CNT_W       width of instr_count
module control_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_ORI  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;
    localparam logic [4:0] OP_NEG  = 5'd13;
    localparam logic [4:0] OP_NOT  = 5'd14;
    localparam logic [4:0] OP_LD   = 5'd15;
    localparam logic [4:0] OP_ST   = 5'd16;
    localparam logic [4:0] OP_MFHI = 5'd17;
    localparam logic [4:0] OP_MFLO = 5'd18;
    localparam logic [4:0] OP_HALT = 5'd20;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    // Wait counter only has to reach WAIT_LIMIT-1.
    localparam int              WC_W        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam int              WAIT_LAST_I = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
    localparam logic [WC_W-1:0] WAIT_LAST   = WC_W'(WAIT_LAST_I);
    localparam bit              WAIT_EN     = (WAIT_LIMIT != 0);

    typedef struct packed {
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic        pc_out, inc_pc, mar_in, mdr_in, mdr_read, mdr_out, ir_in, y_in;
        logic        z_in, zlow_out, zhigh_out, hi_in, hi_out, lo_in, lo_out, c_out;
        logic [3:0]  alu;
        logic        mem_read, mem_write, illegal;
    } ctl_t;

    state_t           state, nxt;
    logic [WC_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] count;
    logic             timeout_q;
    ctl_t             ctl, ctl_g;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [3:0] alu_op;
    logic       is_rtype, is_imm, is_muldiv, is_negnot, is_ld, is_st, is_mem;
    logic       is_wb, has_t4, is_mfhi, is_mflo, is_halt, is_illegal;
    logic       waiting, expire, retire;

    assign op = bus.ir[31:27];
    assign ra = bus.ir[26:23];
    assign rb = bus.ir[22:19];
    assign rc = bus.ir[18:15];

    assign is_rtype   = (op <= 5'd7);
    assign is_imm     = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    assign is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
    assign is_negnot  = (op == OP_NEG) || (op == OP_NOT);
    assign is_ld      = (op == OP_LD);
    assign is_st      = (op == OP_ST);
    assign is_mem     = is_ld || is_st;
    assign is_mfhi    = (op == OP_MFHI);
    assign is_mflo    = (op == OP_MFLO);
    assign is_halt    = (op == OP_HALT);
    assign is_illegal = (op > OP_HALT);
    // ALU ops whose result goes back to ra at T5
    assign is_wb      = is_rtype || is_imm || is_negnot;
    assign has_t4     = is_wb || is_muldiv || is_mem;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    always_comb begin
        alu_op = ALU_ADD;
        if (is_rtype) begin
            alu_op = op[3:0];   // R-type opcodes share the ALU encoding
        end else begin
            case (op)
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_MUL:  alu_op = ALU_MUL;
                OP_DIV:  alu_op = ALU_DIV;
                OP_NEG:  alu_op = ALU_NEG;
                OP_NOT:  alu_op = ALU_NOT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    // Memory wait states: fetch read, LD data read, ST data write.
    assign waiting = (state == T1) || ((state == T6) && is_ld) || ((state == T7) && is_st);
    // A ready on the last allowed cycle still completes the access.
    assign expire  = WAIT_EN && waiting && !bus.mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        nxt = T0;
        case (state)
            T0:      nxt = bus.stop ? T0 : T1;
            T1:      nxt = bus.mem_ready ? T2 : T1;
            T2:      nxt = T3;
            T3:      nxt = is_halt ? HALT : (has_t4 ? T4 : T0);
            T4:      nxt = has_t4 ? T5 : T0;
            T5:      nxt = (is_muldiv || is_mem) ? T6 : T0;
            T6: begin
                if (is_ld)      nxt = bus.mem_ready ? T7 : T6;
                else if (is_st) nxt = T7;
                else            nxt = T0;
            end
            T7:      nxt = (is_st && !bus.mem_ready) ? T7 : T0;
            HALT:    nxt = HALT;
            default: nxt = T0;
        endcase
        if (expire) nxt = HALT;
    end

    // An instruction retires when its last step hands back to fetch; a HALT
    // opcode retires on its way into HALT. Timeouts do not retire anything.
    assign retire = ((state == T3) && is_halt) ||
                    ((state != T0) && (state != T1) && (state != T2) &&
                     (state != HALT) && (nxt == T0));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= T0;
            wait_cnt  <= '0;
            count     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= nxt;
            // Every wait state is entered from a non-wait state, so the
            // counter is already zero on entry.
            if (waiting && !bus.mem_ready && !expire) wait_cnt <= wait_cnt + 1'b1;
            else                                      wait_cnt <= '0;
            if (expire) timeout_q <= 1'b1;
            if (retire) count <= count + 1'b1;
        end
    end

    always_comb begin
        ctl = '0;
        case (state)
            T0: begin
                if (!bus.stop) begin
                    ctl.pc_out = 1'b1;
                    ctl.mar_in = 1'b1;
                    ctl.inc_pc = 1'b1;
                end
            end
            T1: begin
                ctl.mem_read = 1'b1;
                ctl.mdr_read = 1'b1;
                ctl.mdr_in   = 1'b1;
            end
            T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            T3: begin
                if (is_illegal) begin
                    ctl.illegal = 1'b1;
                end else if (is_muldiv) begin
                    ctl.reg_out = onehot(ra);
                    ctl.y_in    = 1'b1;
                end else if (is_mfhi) begin
                    ctl.hi_out = 1'b1;
                    ctl.reg_in = onehot(ra);
                end else if (is_mflo) begin
                    ctl.lo_out = 1'b1;
                    ctl.reg_in = onehot(ra);
                end else if (is_wb || is_mem) begin
                    ctl.reg_out = onehot(rb);
                    ctl.y_in    = 1'b1;
                end
            end
            T4: begin
                if (has_t4) begin
                    ctl.z_in = 1'b1;
                    ctl.alu  = alu_op;
                    if (is_rtype)              ctl.reg_out = onehot(rc);
                    else if (is_imm || is_mem) ctl.c_out   = 1'b1;
                    else                       ctl.reg_out = onehot(rb);
                end
            end
            T5: begin
                if (has_t4) ctl.zlow_out = 1'b1;
                if (is_wb)          ctl.reg_in = onehot(ra);
                else if (is_muldiv) ctl.lo_in  = 1'b1;
                else if (is_mem)    ctl.mar_in = 1'b1;
            end
            T6: begin
                if (is_muldiv) begin
                    ctl.zhigh_out = 1'b1;
                    ctl.hi_in     = 1'b1;
                end else if (is_ld) begin
                    ctl.mem_read = 1'b1;
                    ctl.mdr_read = 1'b1;
                    ctl.mdr_in   = 1'b1;
                end else if (is_st) begin
                    // MDR loads from the bus, not from memory
                    ctl.reg_out = onehot(ra);
                    ctl.mdr_in  = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    ctl.mdr_out = 1'b1;
                    ctl.reg_in  = onehot(ra);
                end else if (is_st) begin
                    ctl.mem_write = 1'b1;
                end
            end
            default: ctl = '0;
        endcase
    end

    // Strobes drop the moment clear goes low, not only at the next edge.
    assign ctl_g = clear ? ctl : '0;

    assign bus.reg_in      = ctl_g.reg_in;
    assign bus.reg_out     = ctl_g.reg_out;
    assign bus.PCout       = ctl_g.pc_out;
    assign bus.IncPC       = ctl_g.inc_pc;
    assign bus.MARin       = ctl_g.mar_in;
    assign bus.MDRin       = ctl_g.mdr_in;
    assign bus.MDRread     = ctl_g.mdr_read;
    assign bus.MDRout      = ctl_g.mdr_out;
    assign bus.IRin        = ctl_g.ir_in;
    assign bus.Yin         = ctl_g.y_in;
    assign bus.Zin         = ctl_g.z_in;
    assign bus.Zlowout     = ctl_g.zlow_out;
    assign bus.Zhighout    = ctl_g.zhigh_out;
    assign bus.HIin        = ctl_g.hi_in;
    assign bus.HIout       = ctl_g.hi_out;
    assign bus.LOin        = ctl_g.lo_in;
    assign bus.LOout       = ctl_g.lo_out;
    assign bus.Cout        = ctl_g.c_out;
    assign bus.ALUselect   = ctl_g.alu;
    assign bus.mem_read    = ctl_g.mem_read;
    assign bus.mem_write   = ctl_g.mem_write;
    assign bus.illegal_op  = ctl_g.illegal;
    // run reads 1 while reset is held (the reset state is "executing from T0")
    assign bus.run         = !clear || ((state != HALT) && !((state == T0) && bus.stop));
    assign bus.mem_timeout = timeout_q;
    assign bus.instr_count = count;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    localparam int WL = 16;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pco, inc, marin, mdrin, mdrrd, mdro, irin, yin;
        logic zin, zlo, zhi, hiin, hio, loin, loo, cout;
        logic [3:0]  alu;
        logic mrd, mwr, run, ill, tmo;
        logic [31:0] cnt;
    } cw_t;

    logic clock;
    logic clear;

    control_sequencer_if #(.CNT_W(32)) bus ();

    control_sequencer #(.WAIT_LIMIT(WL), .CNT_W(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    cw_t   exp_q[$];
    string nm_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    model_cnt;
    bit    model_tmo;
    bit    halted;

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h0001 << i;
    endfunction

    function automatic cw_t blk();
        cw_t w;
        w = '0;
        w.run = 1'b1;
        return w;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU code each opcode is meant to use in its compute step
    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'd8:    return 4'd0;
            5'd9:    return 4'd2;
            5'd10:   return 4'd3;
            5'd11:   return 4'd8;
            5'd12:   return 4'd9;
            5'd13:   return 4'd10;
            5'd14:   return 4'd11;
            5'd15, 5'd16: return 4'd0;
            default: return op[3:0];
        endcase
    endfunction

    function automatic cw_t sample();
        cw_t a;
        a.rin = bus.reg_in;      a.rout = bus.reg_out;
        a.pco = bus.PCout;       a.inc = bus.IncPC;     a.marin = bus.MARin;
        a.mdrin = bus.MDRin;     a.mdrrd = bus.MDRread; a.mdro = bus.MDRout;
        a.irin = bus.IRin;       a.yin = bus.Yin;       a.zin = bus.Zin;
        a.zlo = bus.Zlowout;     a.zhi = bus.Zhighout;  a.hiin = bus.HIin;
        a.hio = bus.HIout;       a.loin = bus.LOin;     a.loo = bus.LOout;
        a.cout = bus.Cout;       a.alu = bus.ALUselect;
        a.mrd = bus.mem_read;    a.mwr = bus.mem_write; a.run = bus.run;
        a.ill = bus.illegal_op;  a.tmo = bus.mem_timeout;
        a.cnt = bus.instr_count;
        return a;
    endfunction

    // One clock cycle of stimulus plus the control word expected in it.
    task automatic cyc(input cw_t w, input string nm, input logic mr, input logic st,
                       input logic rstn, input logic [31:0] irv);
        @(posedge clock);
        #1;
        clear         = rstn;
        bus.mem_ready = mr;
        bus.stop      = st;
        bus.ir        = irv;
        w.cnt = model_cnt;
        w.tmo = model_tmo;
        exp_q.push_back(w);
        nm_q.push_back(nm);
    endtask

    // d cycles of mem_ready=0 then one with mem_ready=1, unless the limit runs out.
    task automatic mem_wait(input cw_t w, input string nm, input int d,
                            input logic [31:0] irv, output bit to);
        to = 1'b0;
        for (int i = 0; i < d && i < WL; i++) cyc(w, nm, 1'b0, rnd(), 1'b1, irv);
        if (d >= WL) begin
            to        = 1'b1;
            model_tmo = 1'b1;
            halted    = 1'b1;
        end else begin
            cyc(w, nm, 1'b1, rnd(), 1'b1, irv);
        end
    endtask

    task automatic halt_cycles(input int n);
        cw_t w;
        w = blk();
        w.run = 1'b0;
        for (int i = 0; i < n; i++) cyc(w, "halt", rnd(), rnd(), 1'b1, $urandom);
    endtask

    task automatic do_reset(input int n);
        model_cnt = 0;
        model_tmo = 1'b0;
        halted    = 1'b0;
        for (int i = 0; i < n; i++) cyc(blk(), "reset", rnd(), rnd(), 1'b0, $urandom);
    endtask

    task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input int d_f, input int d_m,
                             input int pause, input bit abort_t7);
        logic [31:0] irv;
        cw_t         w;
        bit          to;
        cw_t         s[$];
        bit          wt[$];
        string       sn[$];
        irv = {op, ra, rb, rc, 15'($urandom)};
        for (int i = 0; i < pause; i++) begin
            w = blk();
            w.run = 1'b0;
            cyc(w, "pause", rnd(), 1'b1, 1'b1, irv);
        end
        w = blk(); w.pco = 1; w.marin = 1; w.inc = 1;
        cyc(w, "T0_fetch", rnd(), 1'b0, 1'b1, irv);
        w = blk(); w.mrd = 1; w.mdrrd = 1; w.mdrin = 1;
        mem_wait(w, "T1_read", d_f, irv, to);
        if (to) return;
        w = blk(); w.mdro = 1; w.irin = 1;
        cyc(w, "T2_ir", rnd(), rnd(), 1'b1, irv);

        if (op <= 5'd14 && !(op inside {5'd11, 5'd12})) begin
            w = blk(); w.rout = oh(rb); w.yin = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T3_alu");
            w = blk(); w.zin = 1; w.alu = alu_of(op);
            if (op <= 5'd7)                    w.rout = oh(rc);
            else if (op inside {8, 9, 10})     w.cout = 1;
            else                               w.rout = oh(rb);
            s.push_back(w); wt.push_back(0); sn.push_back("T4_alu");
            w = blk(); w.zlo = 1; w.rin = oh(ra);
            s.push_back(w); wt.push_back(0); sn.push_back("T5_wb");
        end else if (op inside {5'd11, 5'd12}) begin
            w = blk(); w.rout = oh(ra); w.yin = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T3_md");
            w = blk(); w.rout = oh(rb); w.zin = 1; w.alu = alu_of(op);
            s.push_back(w); wt.push_back(0); sn.push_back("T4_md");
            w = blk(); w.zlo = 1; w.loin = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T5_lo");
            w = blk(); w.zhi = 1; w.hiin = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T6_hi");
        end else if (op inside {5'd15, 5'd16}) begin
            w = blk(); w.rout = oh(rb); w.yin = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T3_ea");
            w = blk(); w.cout = 1; w.zin = 1; w.alu = 4'd0;
            s.push_back(w); wt.push_back(0); sn.push_back("T4_ea");
            w = blk(); w.zlo = 1; w.marin = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T5_mar");
            if (op == 5'd15) begin
                w = blk(); w.mrd = 1; w.mdrrd = 1; w.mdrin = 1;
                s.push_back(w); wt.push_back(1); sn.push_back("T6_ldrd");
                w = blk(); w.mdro = 1; w.rin = oh(ra);
                s.push_back(w); wt.push_back(0); sn.push_back("T7_ldwb");
            end else begin
                w = blk(); w.rout = oh(ra); w.mdrin = 1;
                s.push_back(w); wt.push_back(0); sn.push_back("T6_stmdr");
                w = blk(); w.mwr = 1;
                s.push_back(w); wt.push_back(1); sn.push_back("T7_stwr");
            end
        end else begin
            w = blk();
            if (op == 5'd17)      begin w.hio = 1; w.rin = oh(ra); end
            else if (op == 5'd18) begin w.loo = 1; w.rin = oh(ra); end
            else if (op > 5'd20)  w.ill = 1;
            s.push_back(w); wt.push_back(0); sn.push_back("T3_misc");
        end

        foreach (s[i]) begin
            if (abort_t7 && sn[i] == "T7_stwr") begin
                model_cnt = 0;
                model_tmo = 1'b0;
                cyc(blk(), "reset_mid_T7", rnd(), rnd(), 1'b0, irv);
                return;
            end
            if (wt[i]) begin
                mem_wait(s[i], sn[i], d_m, irv, to);
                if (to) return;
            end else begin
                cyc(s[i], sn[i], rnd(), rnd(), 1'b1, irv);
            end
        end
        model_cnt++;
        if (op == 5'd20) halted = 1'b1;
    endtask

    cw_t   mon_e, mon_a;
    string mon_nm;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = nm_q.pop_front();
            mon_a  = sample();
            n_chk++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s @%0t: got %h expected %h", mon_nm, $time, mon_a, mon_e);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, df, dm, ps;
        logic [4:0] op;
        clear = 1'b0; bus.ir = '0; bus.mem_ready = 1'b0; bus.stop = 1'b0;
        model_cnt = 0; model_tmo = 1'b0; halted = 1'b0;
        do_reset(3);

        run_instr(5'd0,  4'd3, 4'd1, 4'd2, 0, 0, 0, 0);   // ADD r3,r1,r2
        run_instr(5'd15, 4'd4, 4'd2, 4'd0, 3, 3, 0, 0);   // LD r4,8(r2), slow memory
        run_instr(5'd11, 4'd5, 4'd6, 4'd0, 0, 0, 0, 0);   // MUL r5,r6
        run_instr(5'd25, 4'd1, 4'd2, 4'd3, 0, 0, 5, 0);   // paused, then illegal opcode
        run_instr(5'd16, 4'd7, 4'd3, 4'd0, 1, 2, 0, 1);   // ST, reset during T7
        run_instr(5'd9,  4'd2, 4'd8, 4'd0, 0, 0, 0, 0);   // ANDI after reset
        run_instr(5'd15, 4'd9, 4'd1, 4'd0, 0, 15, 0, 0);  // ready on the last allowed cycle
        run_instr(5'd16, 4'd1, 4'd2, 4'd0, 15, 1, 0, 0);
        run_instr(5'd0,  4'd3, 4'd1, 4'd2, 20, 0, 0, 0);  // fetch timeout
        halt_cycles(4);
        do_reset(2);
        run_instr(5'd20, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);   // HALT
        halt_cycles(3);
        do_reset(2);

        for (int n = 0; n < 200; n++) begin
            op = 5'($urandom_range(0, 31));
            r  = $urandom_range(0, 99);
            df = (r < 2) ? WL + $urandom_range(0, 3) : (r < 6) ? 15 : $urandom_range(0, 3);
            r  = $urandom_range(0, 99);
            dm = (r < 3) ? WL + $urandom_range(0, 3) : (r < 8) ? 15 : $urandom_range(0, 3);
            ps = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 3) : 0;
            run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), df, dm, ps,
                      (op == 5'd16) && ($urandom_range(0, 9) == 0));
            if (halted) begin
                halt_cycles($urandom_range(1, 4));
                do_reset(2);
            end
        end

        repeat (3) @(negedge clock);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
